// File: rtl/uart_interrupt_arbiter.sv
// UART interrupt scheduler: latches RX/TX/config events, arbitrates by fixed
// priority and runs the raise / IACK / gap handshake behind int_o and isr_o.
module uart_interrupt_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       overrun_i,
  input  logic       parity_err_i,
  input  logic       frame_err_i,
  input  logic       rx_ready_i,
  input  logic       tx_done_i,
  input  logic       cfg_event_i,
  input  logic [5:0] int_enable_i,
  input  logic       iack_i,
  output logic       int_o,
  output logic [7:0] isr_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  // Source index doubles as priority rank: INTID = index + 1.
  localparam int unsigned SRC_RXRDY = 3;
  localparam int unsigned NUM_SRC   = 6;

  logic [1:0] state_q, state_d;
  logic [5:0] pend_q, pend_d;
  logic [5:0] en_q, en_d;
  logic [2:0] cur_id_q, cur_id_d;
  logic       int_q, int_d;
  logic [7:0] isr_q, isr_d;

  logic [5:0] pulse;
  logic [5:0] eligible;
  logic [5:0] ack_clr;
  logic [2:0] win_id;
  logic       win_found;
  logic       ack_fire;

  always_comb begin
    pulse    = {cfg_event_i, tx_done_i, 1'b0, frame_err_i, parity_err_i, overrun_i};
    eligible = pend_q & en_q;
    ack_fire = (state_q == ST_ASSERT) && iack_i;
    en_d     = int_enable_i;
  end

  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && !win_found) begin
        win_id    = 3'(i + 1);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    ack_clr = '0;
    if (ack_fire) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (cur_id_q == 3'(i + 1)) ack_clr[i] = 1'b1;
      end
    end
  end

  // A pulse coinciding with the clearing ack wins, so the source stays pending.
  always_comb begin
    pend_d            = pulse | (pend_q & ~ack_clr);
    pend_d[SRC_RXRDY] = rx_ready_i;
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_ASSERT;
          cur_id_d = win_id;
        end
      end
      ST_ASSERT: begin
        if (iack_i) state_d = ST_GAP;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are built from next-state values so they land in flops.
  always_comb begin
    int_d = (state_d == ST_ASSERT);
    isr_d = {pend_d[3], pend_d[2], pend_d[1], pend_d[0],
             (state_d == ST_ASSERT) ? cur_id_d : 3'b000, 1'b0};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      en_q     <= '0;
      cur_id_q <= '0;
      int_q    <= 1'b0;
      isr_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      cur_id_q <= cur_id_d;
      int_q    <= int_d;
      isr_q    <= isr_d;
    end
  end

  assign int_o = int_q;
  assign isr_o = isr_q;

endmodule

// File: tb/tb_uart_interrupt_arbiter.sv
// Directed scoreboard bench for uart_interrupt_arbiter: each step queues the
// expected {int_o, isr_o} and pops it one cycle later.
module tb_uart_interrupt_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ovr, par, frm, rx, tx, cfg, iack;
  logic [5:0] en;
  logic       int_o;
  logic [7:0] isr_o;

  typedef struct {
    string      tag;
    logic       irq;
    logic [7:0] isr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  uart_interrupt_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .overrun_i    (ovr),
    .parity_err_i (par),
    .frame_err_i  (frm),
    .rx_ready_i   (rx),
    .tx_done_i    (tx),
    .cfg_event_i  (cfg),
    .int_enable_i (en),
    .iack_i       (iack),
    .int_o        (int_o),
    .isr_o        (isr_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic irq, input logic [7:0] isr);
    exp_t e;
    e.tag = tag;
    e.irq = irq;
    e.isr = isr;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t       e;
    logic [8:0] obs, want;
    checks++;
    obs = {int_o, isr_o};
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed int=%0b isr=%02h required a queued entry", obs[8], obs[7:0]);
    end else begin
      e    = sb.pop_front();
      want = {e.irq, e.isr};
      assert (obs === want) else begin
        errors++;
        $error("FAIL %s observed int=%0b isr=%02h required int=%0b isr=%02h",
               e.tag, obs[8], obs[7:0], want[8], want[7:0]);
      end
    end
  endtask

  task automatic step(input string tag, input logic irq, input logic [7:0] isr);
    push(tag, irq, isr);
    tick();
    chk();
  endtask

  task automatic check_now(input string tag, input logic irq, input logic [7:0] isr);
    push(tag, irq, isr);
    chk();
  endtask

  initial begin
    rst = 1'b1;
    {ovr, par, frm, rx, tx, cfg, iack} = '0;
    en = '0;
    tick();
    tick();
    check_now("reset", 1'b0, 8'h00);
    rst = 1'b0;

    // 1: quiet idle
    for (int i = 0; i < 20; i++) step("idle", 1'b0, 8'h00);

    // 2: single frame error
    en = 6'h3F;
    step("t2_en", 1'b0, 8'h00);
    frm = 1'b1;
    step("t2_pend", 1'b0, 8'h40);
    frm = 1'b0;
    step("t2_raise", 1'b1, 8'h46);
    iack = 1'b1;
    step("t2_gap", 1'b0, 8'h00);
    iack = 1'b0;
    for (int i = 0; i < 3; i++) step("t2_quiet", 1'b0, 8'h00);

    // 3: overrun and tx_done together
    ovr = 1'b1; tx = 1'b1;
    step("t3_pend", 1'b0, 8'h10);
    ovr = 1'b0; tx = 1'b0;
    step("t3_ovr", 1'b1, 8'h12);
    iack = 1'b1;
    step("t3_gap", 1'b0, 8'h00);
    iack = 1'b0;
    step("t3_idle", 1'b0, 8'h00);
    step("t3_tx", 1'b1, 8'h0A);

    // 4: parity during TXDONE assert does not preempt
    par = 1'b1;
    step("t4_par_pend", 1'b1, 8'h2A);
    par = 1'b0;
    step("t4_hold", 1'b1, 8'h2A);
    iack = 1'b1;
    step("t4_gap", 1'b0, 8'h20);
    iack = 1'b0;
    step("t4_idle", 1'b0, 8'h20);
    step("t4_par", 1'b1, 8'h24);
    par = 1'b1; iack = 1'b1;
    step("t4_setwins_gap", 1'b0, 8'h20);
    par = 1'b0; iack = 1'b0;
    step("t4_setwins_idle", 1'b0, 8'h20);
    step("t4_reraise", 1'b1, 8'h24);
    iack = 1'b1;
    step("t4_gap2", 1'b0, 8'h00);
    iack = 1'b0;
    for (int i = 0; i < 3; i++) step("t4_quiet", 1'b0, 8'h00);

    // 5: RXRDY level source, only RXRDY enabled
    en = 6'h08;
    step("t5_en", 1'b0, 8'h00);
    rx = 1'b1;
    step("t5_pend", 1'b0, 8'h80);
    step("t5_raise", 1'b1, 8'h88);
    iack = 1'b1;
    step("t5_gap", 1'b0, 8'h80);
    iack = 1'b0;
    step("t5_idle", 1'b0, 8'h80);
    step("t5_reraise", 1'b1, 8'h88);
    rx = 1'b0;
    step("t5_drop", 1'b1, 8'h08);
    iack = 1'b1;
    step("t5_gap2", 1'b0, 8'h00);
    iack = 1'b0;
    for (int i = 0; i < 3; i++) step("t5_quiet", 1'b0, 8'h00);

    // 6: masked CFG, stray iack, unmask, mask in assert, async reset
    en = 6'h1F;
    step("t6_en", 1'b0, 8'h00);
    cfg = 1'b1;
    step("t6_masked", 1'b0, 8'h00);
    cfg = 1'b0;
    for (int i = 0; i < 2; i++) step("t6_masked_hold", 1'b0, 8'h00);
    iack = 1'b1;
    step("t6_iack_idle", 1'b0, 8'h00);
    iack = 1'b0;
    step("t6_iack_idle2", 1'b0, 8'h00);
    en = 6'h3F;
    step("t6_unmask", 1'b0, 8'h00);
    step("t6_raise", 1'b1, 8'h0C);
    en = 6'h1F;
    step("t6_mask_in_assert", 1'b1, 8'h0C);
    step("t6_mask_in_assert2", 1'b1, 8'h0C);
    #2 rst = 1'b1;
    #1 check_now("t6_async_rst", 1'b0, 8'h00);
    tick();
    rst = 1'b0;
    en  = 6'h3F;
    for (int i = 0; i < 3; i++) step("t6_after_rst", 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
